// File: rtl/staff_write_scheduler.sv
// Staff write scheduler: a metronome advances the staff cell once per sixteenth-note period
// and streams each non-empty detected-note slot of the closing cell to note memory.
module staff_write_scheduler #(
  parameter int NUM_CELLS  = 48,
  parameter int MIN_PERIOD = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             enable_in,
  input  logic [31:0]      period_in,
  input  logic [4:0][11:0] detected_note_in,
  input  logic             overrun_clr_in,
  output logic [5:0]       current_staff_cell_out,
  output logic             cell_tick_out,
  output logic [8:0]       wr_addr_out,
  output logic [11:0]      wr_data_out,
  output logic             wr_valid_out,
  input  logic             wr_ready_in,
  output logic             busy_out,
  output logic             overrun_out
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_RUN   = 2'd1;
  localparam logic [1:0]  S_WRITE = 2'd2;
  localparam logic [1:0]  S_FLUSH = 2'd3;
  localparam logic [11:0] EMPTY   = 12'h0ff;
  localparam logic [31:0] MIN_P   = 32'(MIN_PERIOD);

  logic [1:0]       state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      per_q, per_d;
  logic [5:0]       cell_q, cell_d;
  logic [5:0]       closing_q, closing_d;
  logic [2:0]       slot_q, slot_d;
  logic [4:0][11:0] snap_q, snap_d;
  logic             tick_q, overrun_q, overrun_d;

  logic [31:0] clamp_per, eff_per;
  logic        count_en, tick, handshake;
  logic        new_found, nxt_found;
  logic [2:0]  new_slot, nxt_slot;
  logic [11:0] cur_data;

  always_comb begin
    clamp_per = (period_in < MIN_P) ? MIN_P : period_in;
    // The period only takes effect at a cell boundary, so mid-cell changes never shorten a cell.
    eff_per   = (cnt_q == 32'd0) ? clamp_per : per_q;
    count_en  = enable_in && (state_q == S_RUN || state_q == S_WRITE);
    tick      = count_en && (cnt_q == eff_per - 32'd1);
    handshake = (state_q == S_WRITE) && wr_ready_in;

    new_found = 1'b0;
    new_slot  = 3'd0;
    nxt_found = 1'b0;
    nxt_slot  = 3'd0;
    cur_data  = 12'd0;
    for (int i = 4; i >= 0; i--) begin
      if (detected_note_in[i] != EMPTY) begin
        new_found = 1'b1;
        new_slot  = 3'(i);
      end
      if (3'(i) > slot_q && snap_q[i] != EMPTY) begin
        nxt_found = 1'b1;
        nxt_slot  = 3'(i);
      end
      if (slot_q == 3'(i)) cur_data = snap_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    per_d     = (cnt_q == 32'd0) ? clamp_per : per_q;
    cell_d    = cell_q;
    closing_d = closing_q;
    slot_d    = slot_q;
    snap_d    = snap_q;
    cnt_d     = (!count_en || tick) ? 32'd0 : cnt_q + 32'd1;
    overrun_d = (overrun_q && !overrun_clr_in) || (tick && state_q == S_WRITE);

    if (tick) cell_d = (cell_q == 6'(NUM_CELLS - 1)) ? 6'd0 : cell_q + 6'd1;

    case (state_q)
      S_IDLE: if (enable_in) state_d = S_RUN;
      S_RUN: begin
        if (!enable_in) begin
          state_d = S_IDLE;
        end else if (tick) begin
          snap_d    = detected_note_in;
          closing_d = cell_q;
          // Only non-empty slots are visited; an all-empty snapshot never leaves RUN.
          if (new_found) begin
            state_d = S_WRITE;
            slot_d  = new_slot;
          end
        end
      end
      S_WRITE: begin
        if (handshake) begin
          if (nxt_found) slot_d = nxt_slot;
          else           state_d = enable_in ? S_RUN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      cnt_q     <= 32'd0;
      per_q     <= MIN_P;
      cell_q    <= 6'd0;
      closing_q <= 6'd0;
      slot_q    <= 3'd0;
      snap_q    <= {5{EMPTY}};
      tick_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      cell_q    <= cell_d;
      closing_q <= closing_d;
      slot_q    <= slot_d;
      snap_q    <= snap_d;
      tick_q    <= tick;
      overrun_q <= overrun_d;
    end
  end

  assign current_staff_cell_out = cell_q;
  assign cell_tick_out          = tick_q;
  assign wr_valid_out           = (state_q == S_WRITE);
  assign wr_addr_out            = wr_valid_out ? {closing_q, slot_q} : 9'd0;
  assign wr_data_out            = wr_valid_out ? cur_data : 12'd0;
  assign busy_out               = (state_q == S_WRITE) || (state_q == S_FLUSH);
  assign overrun_out            = overrun_q;

endmodule

// File: tb/tb_staff_write_scheduler.sv
// Bench for staff_write_scheduler: vector table, directed corner sequences, and a random run
// compared against a queue-based reference model of the write stream.
module tb_staff_write_scheduler;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic             enable_in = 1'b0;
  logic [31:0]      period_in = 32'd20;
  logic [4:0][11:0] detected_note_in = {5{12'h0ff}};
  logic             overrun_clr_in = 1'b0;
  logic             wr_ready_in = 1'b1;
  logic [5:0]       current_staff_cell_out;
  logic             cell_tick_out;
  logic [8:0]       wr_addr_out;
  logic [11:0]      wr_data_out;
  logic             wr_valid_out;
  logic             busy_out;
  logic             overrun_out;

  staff_write_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .period_in(period_in),
    .detected_note_in(detected_note_in), .overrun_clr_in(overrun_clr_in),
    .current_staff_cell_out(current_staff_cell_out), .cell_tick_out(cell_tick_out),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .wr_valid_out(wr_valid_out),
    .wr_ready_in(wr_ready_in), .busy_out(busy_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    enable_in = 1'b0;
    overrun_clr_in = 1'b0;
    step();
    step();
    rst_in = 1'b0;
  endtask

  // Steps until cell_tick_out is seen; an expired bound is itself a failed check.
  task automatic wait_tick(input string name, input int bound);
    bit seen = 0;
    for (int n = 0; n < bound && !seen; n++) begin
      step();
      if (cell_tick_out) seen = 1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  // Reference model: a cell metronome plus a FIFO of pending (addr, data) writes.
  logic [20:0] m_q[$];
  bit m_running, m_tickout, m_over;
  int m_phase, m_per, m_cell;

  task automatic model_reset();
    m_q.delete();
    m_running = 0; m_tickout = 0; m_over = 0;
    m_phase = 0; m_per = 16; m_cell = 0;
  endtask

  task automatic model_step(input bit en, input int per, input logic [4:0][11:0] notes,
                            input bit rdy, input bit clr);
    bit writing, tick;
    writing = (m_q.size() > 0);
    tick = 0;
    if (writing && rdy) void'(m_q.pop_front());
    if (!(m_running && en)) begin
      m_phase = 0;
    end else begin
      if (m_phase == 0) m_per = (per < 16) ? 16 : per;
      if (m_phase == m_per - 1) begin
        tick = 1;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
    m_over = (m_over && !clr) || (tick && writing);
    if (tick) begin
      if (!writing)
        for (int i = 0; i < 5; i++)
          if (notes[i] != 12'h0ff) m_q.push_back({6'(m_cell), 3'(i), notes[i]});
      m_cell = (m_cell + 1) % 48;
    end
    m_tickout = tick;
    m_running = en || (m_q.size() > 0);
  endtask

  typedef struct {
    logic [31:0] period;
    logic [59:0] notes;
    int          exp_gap;
    int          exp_writes;
  } vec_t;

  vec_t tv[6];

  initial begin
    tv[0] = '{32'd20, {5{12'h0ff}}, 20, 0};
    tv[1] = '{32'd3,  {5{12'h0ff}}, 16, 0};
    tv[2] = '{32'd17, {12'h843, 12'h0ff, 12'h240, 12'h0ff, 12'h13c}, 17, 3};
    tv[3] = '{32'd0,  {12'h005, 12'h004, 12'h003, 12'h002, 12'h001}, 16, 5};
    tv[4] = '{32'd25, {12'h7ab, 12'h0ff, 12'h0ff, 12'h0ff, 12'h0ff}, 25, 1};
    tv[5] = '{32'd16, {12'h0ff, 12'hfff, 12'h0ff, 12'h100, 12'h0ff}, 16, 2};

    do_reset();
    chk("rst_cell", 32'(current_staff_cell_out), 0);
    chk("rst_tick", 32'(cell_tick_out), 0);
    chk("rst_valid", 32'(wr_valid_out), 0);
    chk("rst_addr", 32'(wr_addr_out), 0);
    chk("rst_data", 32'(wr_data_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_overrun", 32'(overrun_out), 0);

    for (int v = 0; v < 6; v++) begin
      int gap, writes, busy_cycles;
      bit first_valid;
      do_reset();
      period_in = tv[v].period;
      detected_note_in = tv[v].notes;
      wr_ready_in = 1'b1;
      enable_in = 1'b1;
      wait_tick($sformatf("v%0d_first_tick", v), 200);
      chk($sformatf("v%0d_cell_after_tick", v), 32'(current_staff_cell_out), 1);
      first_valid = wr_valid_out;
      chk($sformatf("v%0d_first_write_at_tick_plus1", v), 32'(first_valid),
          32'(tv[v].exp_writes > 0));
      gap = 0; writes = 0; busy_cycles = 0;
      for (int n = 0; n < 100 && gap == 0; n++) begin
        if (wr_valid_out && wr_ready_in) writes++;
        if (busy_out) busy_cycles++;
        step();
        if (cell_tick_out) gap = n + 1;
      end
      chk($sformatf("v%0d_tick_gap", v), 32'(gap), 32'(tv[v].exp_gap));
      chk($sformatf("v%0d_writes", v), 32'(writes), 32'(tv[v].exp_writes));
      chk($sformatf("v%0d_busy_cycles", v), 32'(busy_cycles), 32'(tv[v].exp_writes));
    end

    // Full wrap of the staff with empty slots: 48 ticks returns to cell 0, no writes.
    begin
      int wr_seen = 0;
      do_reset();
      period_in = 32'd20;
      detected_note_in = {5{12'h0ff}};
      enable_in = 1'b1;
      for (int t = 0; t < 48; t++) begin
        wait_tick("wrap_tick", 40);
        if (wr_valid_out) wr_seen++;
      end
      chk("wrap_cell", 32'(current_staff_cell_out), 0);
      chk("wrap_no_writes", 32'(wr_seen), 0);
    end

    // Closing cell 5 with three occupied slots.
    do_reset();
    period_in = 32'd20;
    detected_note_in = {5{12'h0ff}};
    wr_ready_in = 1'b1;
    enable_in = 1'b1;
    for (int t = 0; t < 5; t++) wait_tick("c5_reach", 40);
    chk("c5_cell_is_5", 32'(current_staff_cell_out), 5);
    detected_note_in = {12'h843, 12'h0ff, 12'h240, 12'h0ff, 12'h13c};
    wait_tick("c5_tick", 40);
    chk("c5_cell_is_6", 32'(current_staff_cell_out), 6);
    chk("c5_w0", {wr_valid_out, 2'b0, wr_addr_out, 8'b0, wr_data_out}, {1'b1, 2'b0, 9'h028, 8'b0, 12'h13c});
    step();
    chk("c5_w1", {wr_valid_out, 2'b0, wr_addr_out, 8'b0, wr_data_out}, {1'b1, 2'b0, 9'h02a, 8'b0, 12'h240});
    step();
    chk("c5_w2", {wr_valid_out, 2'b0, wr_addr_out, 8'b0, wr_data_out}, {1'b1, 2'b0, 9'h02c, 8'b0, 12'h843});
    step();
    chk("c5_done_valid", 32'(wr_valid_out), 0);
    chk("c5_done_busy", 32'(busy_out), 0);

    // Stalled write: held stable across the next tick, which overruns but still advances.
    wr_ready_in = 1'b0;
    wait_tick("ov_tick1", 40);
    chk("ov_first_write", {wr_valid_out, 2'b0, wr_addr_out, 8'b0, wr_data_out}, {1'b1, 2'b0, 9'h030, 8'b0, 12'h13c});
    begin
      int unstable = 0;
      for (int n = 0; n < 19; n++) begin
        step();
        if (!wr_valid_out || wr_addr_out != 9'h030 || wr_data_out != 12'h13c || cell_tick_out)
          unstable++;
      end
      chk("ov_stable_cycles", 32'(unstable), 0);
    end
    chk("ov_not_yet", 32'(overrun_out), 0);
    wait_tick("ov_tick2", 5);
    chk("ov_cell_advanced", 32'(current_staff_cell_out), 8);
    chk("ov_set", 32'(overrun_out), 1);
    chk("ov_addr_held", 32'(wr_addr_out), 32'h030);
    overrun_clr_in = 1'b1;
    step();
    overrun_clr_in = 1'b0;
    chk("ov_cleared", 32'(overrun_out), 0);

    // Enable dropped mid-write: the sequence drains, then everything stays quiet.
    do_reset();
    period_in = 32'd20;
    detected_note_in = {12'h843, 12'h0ff, 12'h240, 12'h0ff, 12'h13c};
    wr_ready_in = 1'b0;
    enable_in = 1'b1;
    wait_tick("en_tick", 40);
    enable_in = 1'b0;
    for (int n = 0; n < 5; n++) step();
    chk("en_still_busy", 32'(busy_out), 1);
    wr_ready_in = 1'b1;
    begin
      int xfers = 0, ticks = 0;
      for (int n = 0; n < 10; n++) begin
        if (wr_valid_out && wr_ready_in) xfers++;
        step();
      end
      chk("en_drain_writes", 32'(xfers), 3);
      chk("en_idle_busy", 32'(busy_out), 0);
      for (int n = 0; n < 60; n++) begin
        step();
        if (cell_tick_out || wr_valid_out) ticks++;
      end
      chk("en_no_ticks", 32'(ticks), 0);
      chk("en_cell_held", 32'(current_staff_cell_out), 1);
    end
    enable_in = 1'b1;
    wait_tick("en_resume_tick", 40);
    chk("en_resume_cell", 32'(current_staff_cell_out), 2);

    // Asynchronous reset in the middle of a stalled write.
    wr_ready_in = 1'b0;
    wait_tick("ar_tick", 40);
    chk("ar_in_write", 32'(wr_valid_out), 1);
    enable_in = 1'b0;
    #3 rst_in = 1'b1;
    #1;
    chk("ar_outputs_zero", {current_staff_cell_out, cell_tick_out, wr_addr_out, wr_data_out,
                            wr_valid_out, busy_out, overrun_out}, 0);
    step();
    rst_in = 1'b0;
    wr_ready_in = 1'b1;
    begin
      int vseen = 0;
      for (int n = 0; n < 40; n++) begin
        step();
        if (wr_valid_out) vseen++;
      end
      chk("ar_no_writes_after", 32'(vseen), 0);
    end

    // Random run against the reference model.
    do_reset();
    model_reset();
    enable_in = 1'b1;
    for (int c = 0; c < 3000 && failures < 30; c++) begin
      bit en, rdy, clr;
      int per;
      logic [4:0][11:0] notes;
      chk("rnd_cell", 32'(current_staff_cell_out), 32'(m_cell));
      chk("rnd_tick", 32'(cell_tick_out), 32'(m_tickout));
      chk("rnd_valid", 32'(wr_valid_out), 32'(m_q.size() > 0));
      chk("rnd_busy", 32'(busy_out), 32'(m_q.size() > 0));
      chk("rnd_overrun", 32'(overrun_out), 32'(m_over));
      if (m_q.size() > 0) chk("rnd_wr", {11'b0, wr_addr_out, wr_data_out}, {11'b0, m_q[0]});
      en  = ($urandom_range(0, 79) == 0) ? !enable_in : enable_in;
      rdy = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 19) == 0);
      per = $urandom_range(0, 30);
      for (int i = 0; i < 5; i++)
        notes[i] = ($urandom_range(0, 1) == 1) ? 12'h0ff : 12'($urandom);
      enable_in = en;
      wr_ready_in = rdy;
      overrun_clr_in = clr;
      period_in = 32'(per);
      detected_note_in = notes;
      model_step(en, per, notes, rdy, clr);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
